// File: rtl/life_gen_ctrl.sv
// Generation sequencer for the Game-of-Life cell array: row-by-row pattern load,
// timed next-generation commit pulses with pause/single-step, and a generation limit.
//
// state | meaning
// IDLE  | waiting for a command; cmd_step commits one generation
// LOAD  | accepting pattern rows over row_valid/row_ready
// RUN   | free-running, one commit every cfg_period+1 cycles
// PAUSE | timer held; cmd_step commits one generation
module life_gen_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16,
    parameter int DIV_W = 8,
    localparam int RW   = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_period,
    input  logic [GEN_W-1:0] gen_limit,
    input  logic             cmd_load,
    input  logic             cmd_run,
    input  logic             cmd_pause,
    input  logic             cmd_step,
    input  logic             row_valid,
    input  logic [COLS-1:0]  row_data,
    output logic             row_ready,
    output logic             arr_we,
    output logic [RW-1:0]    arr_row,
    output logic [COLS-1:0]  arr_wdata,
    output logic             arr_step,
    output logic [GEN_W-1:0] gen_count,
    output logic [1:0]       state,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    logic [RW-1:0]    row_idx;
    logic [DIV_W-1:0] timer;
    logic [GEN_W-1:0] gen_next;
    logic             limit_hit;
    logic             timer_exp;
    logic             row_last;

    assign gen_next  = gen_count + GEN_W'(1);
    assign limit_hit = (gen_limit != '0) && (gen_next == gen_limit);
    // ">=" lets a period lowered mid-run take effect immediately
    assign timer_exp = (timer >= cfg_period);
    assign row_last  = (row_idx == RW'(ROWS - 1));

    assign row_ready = (state == S_LOAD);
    assign arr_we    = row_valid & row_ready;
    assign arr_row   = row_idx;
    assign arr_wdata = row_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            row_idx   <= '0;
            timer     <= '0;
            gen_count <= '0;
            arr_step  <= 1'b0;
            done      <= 1'b0;
        end else begin
            arr_step <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_load) begin
                        state     <= S_LOAD;
                        row_idx   <= '0;
                        gen_count <= '0;
                    end else if (cmd_run && !cmd_pause) begin
                        state <= S_RUN;
                        timer <= '0;
                    end else if (cmd_step && !cmd_pause) begin
                        arr_step  <= 1'b1;
                        gen_count <= gen_next;
                        done      <= limit_hit;
                    end
                end
                S_LOAD: begin
                    if (arr_we) begin
                        if (row_last) begin
                            state   <= S_IDLE;
                            row_idx <= '0;
                        end else begin
                            row_idx <= row_idx + RW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (cmd_load) begin
                        state     <= S_LOAD;
                        row_idx   <= '0;
                        gen_count <= '0;
                    end else if (cmd_pause) begin
                        state <= S_PAUSE;
                    end else if (timer_exp) begin
                        arr_step  <= 1'b1;
                        timer     <= '0;
                        gen_count <= gen_next;
                        done      <= limit_hit;
                        if (limit_hit) state <= S_PAUSE;
                    end else begin
                        timer <= timer + DIV_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (cmd_load) begin
                        state     <= S_LOAD;
                        row_idx   <= '0;
                        gen_count <= '0;
                    end else if (cmd_run && !cmd_pause) begin
                        state <= S_RUN;
                    end else if (cmd_step && !cmd_pause) begin
                        arr_step  <= 1'b1;
                        gen_count <= gen_next;
                        done      <= limit_hit;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Self-checking bench for life_gen_ctrl: load, stall, run timing, limit, pause/step, reset.
module tb_life_gen_ctrl;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int GEN_W = 16;
    localparam int DIV_W = 8;
    localparam int RW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] cfg_period;
    logic [GEN_W-1:0] gen_limit;
    logic             cmd_load, cmd_run, cmd_pause, cmd_step;
    logic             row_valid;
    logic [COLS-1:0]  row_data;
    logic             row_ready, arr_we, arr_step, done;
    logic [RW-1:0]    arr_row;
    logic [COLS-1:0]  arr_wdata;
    logic [GEN_W-1:0] gen_count;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [RW-1:0]   row;
        logic [COLS-1:0] data;
    } wr_t;
    typedef struct packed {
        int rel;
        int gen;
    } stp_t;

    wr_t  wr_q[$];
    stp_t stp_q[$];

    life_gen_ctrl #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .cfg_period(cfg_period), .gen_limit(gen_limit),
        .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_pause(cmd_pause), .cmd_step(cmd_step),
        .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
        .arr_we(arr_we), .arr_row(arr_row), .arr_wdata(arr_wdata),
        .arr_step(arr_step), .gen_count(gen_count), .state(state), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_load = 0; cmd_run = 0; cmd_pause = 0; cmd_step = 0;
        row_valid = 0; row_data = '0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); cfg_period = '0; gen_limit = '0;
        tick(); tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (gen_count !== '0) begin errors++; $display("FAIL reset_gen: got %0d expected 0", gen_count); end
        checks++; if (arr_step !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_pulses: got step=%b done=%b expected 0 0", arr_step, done); end
        checks++; if (row_ready !== 1'b0 || arr_we !== 1'b0) begin errors++; $display("FAIL reset_ready: got ready=%b we=%b expected 0 0", row_ready, arr_we); end
        rst = 0;
    endtask

    task automatic test_load();
        wr_t e;
        int we_n = 0;
        cmd_load = 1; tick(); cmd_load = 0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL load_enter: got %0d expected 1", state); end
        for (int i = 0; i < ROWS; i++) begin
            row_valid = 1; row_data = COLS'(1 << i);
            wr_q.push_back('{row: RW'(i), data: COLS'(1 << i)});
            #1;
            checks++; if (arr_we !== 1'b1) begin errors++; $display("FAIL load_we row %0d: got %b expected 1", i, arr_we); end
            if (arr_we === 1'b1) begin
                we_n++;
                e = wr_q.pop_front();
                checks++; if (arr_row !== e.row || arr_wdata !== e.data) begin errors++; $display("FAIL load_data: got row=%0d data=%h expected row=%0d data=%h", arr_row, arr_wdata, e.row, e.data); end
            end
            tick();
        end
        row_valid = 0; #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL load_exit: got %0d expected 0", state); end
        checks++; if (gen_count !== '0) begin errors++; $display("FAIL load_gen: got %0d expected 0", gen_count); end
        checks++; if (we_n != ROWS || wr_q.size() != 0) begin errors++; $display("FAIL load_count: got %0d writes expected %0d", we_n, ROWS); end
    endtask

    task automatic test_load_stall();
        wr_t e;
        int we_n = 0;
        int k = 0;
        cmd_load = 1; tick(); cmd_load = 0;
        for (int c = 0; c < 16; c++) begin
            cmd_run = (c < 15);
            row_valid = (c % 2 == 0);
            row_data = 8'hA5 ^ COLS'(k);
            if (row_valid) wr_q.push_back('{row: RW'(k), data: 8'hA5 ^ COLS'(k)});
            if (row_valid) k++;
            #1;
            if (c < 15) begin
                checks++; if (state !== 2'd1 || arr_we !== row_valid) begin errors++; $display("FAIL stall_state c=%0d: got state=%0d we=%b expected 1 %b", c, state, arr_we, row_valid); end
            end
            if (arr_we === 1'b1) begin
                we_n++;
                if (wr_q.size() == 0) begin
                    checks++; errors++; $display("FAIL stall_extra_we: got write row=%0d expected none", arr_row);
                end else begin
                    e = wr_q.pop_front();
                    checks++; if (arr_row !== e.row || arr_wdata !== e.data) begin errors++; $display("FAIL stall_data: got row=%0d data=%h expected row=%0d data=%h", arr_row, arr_wdata, e.row, e.data); end
                end
            end
            tick();
        end
        idle_inputs(); #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL stall_exit: got %0d expected 0", state); end
        checks++; if (we_n != ROWS || wr_q.size() != 0) begin errors++; $display("FAIL stall_count: got %0d writes expected %0d", we_n, ROWS); end
    endtask

    task automatic test_run_timing();
        stp_t e;
        int t0, rel;
        cfg_period = 8'd3; gen_limit = '0;
        cmd_run = 1; tick(); cmd_run = 0;
        t0 = cyc;
        cmd_step = 1;
        for (int k = 1; k <= 5; k++) stp_q.push_back('{rel: 4 * k, gen: k});
        for (int c = 0; c < 22; c++) begin
            tick();
            rel = cyc - t0;
            if (arr_step === 1'b1) begin
                if (stp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL run_extra_step: got pulse at %0d expected none", rel);
                end else begin
                    e = stp_q.pop_front();
                    checks++; if (rel != e.rel || gen_count !== GEN_W'(e.gen)) begin errors++; $display("FAIL run_step: got t=%0d gen=%0d expected t=%0d gen=%0d", rel, gen_count, e.rel, e.gen); end
                end
            end
        end
        cmd_step = 0;
        checks++; if (stp_q.size() != 0) begin errors++; $display("FAIL run_missing: got %0d pending expected 0", stp_q.size()); end
        checks++; if (gen_count !== 16'd5 || state !== 2'd2) begin errors++; $display("FAIL run_end: got gen=%0d state=%0d expected 5 2", gen_count, state); end
    endtask

    task automatic test_limit();
        stp_t e;
        int t0, rel;
        int done_n = 0;
        do_reset();
        cfg_period = 8'd0; gen_limit = 16'd3;
        cmd_run = 1; tick(); cmd_run = 0;
        t0 = cyc;
        for (int k = 1; k <= 3; k++) stp_q.push_back('{rel: k, gen: k});
        for (int c = 0; c < 10; c++) begin
            tick();
            rel = cyc - t0;
            if (done === 1'b1) done_n++;
            checks++; if (done !== (rel == 3)) begin errors++; $display("FAIL limit_done t=%0d: got %b expected %b", rel, done, (rel == 3)); end
            if (arr_step === 1'b1) begin
                if (stp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL limit_extra_step: got pulse at %0d expected none", rel);
                end else begin
                    e = stp_q.pop_front();
                    checks++; if (rel != e.rel || gen_count !== GEN_W'(e.gen)) begin errors++; $display("FAIL limit_step: got t=%0d gen=%0d expected t=%0d gen=%0d", rel, gen_count, e.rel, e.gen); end
                end
            end
        end
        checks++; if (stp_q.size() != 0 || done_n != 1) begin errors++; $display("FAIL limit_count: got pending=%0d done=%0d expected 0 1", stp_q.size(), done_n); end
        checks++; if (state !== 2'd3 || gen_count !== 16'd3) begin errors++; $display("FAIL limit_end: got state=%0d gen=%0d expected 3 3", state, gen_count); end
        gen_limit = '0;
    endtask

    task automatic test_pause_step();
        do_reset();
        cfg_period = 8'd3; gen_limit = '0;
        cmd_run = 1; tick(); cmd_run = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (arr_step !== 1'b0) begin errors++; $display("FAIL pause_early_step: got 1 expected 0"); end
        end
        cmd_pause = 1; tick(); cmd_pause = 0;
        checks++; if (arr_step !== 1'b0 || state !== 2'd3 || gen_count !== '0) begin errors++; $display("FAIL pause_suppress: got step=%b state=%0d gen=%0d expected 0 3 0", arr_step, state, gen_count); end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (arr_step !== 1'b0 || state !== 2'd3) begin errors++; $display("FAIL pause_hold: got step=%b state=%0d expected 0 3", arr_step, state); end
        end
        cmd_step = 1; tick(); cmd_step = 0;
        checks++; if (arr_step !== 1'b1 || gen_count !== 16'd1 || state !== 2'd3) begin errors++; $display("FAIL pause_step: got step=%b gen=%0d state=%0d expected 1 1 3", arr_step, gen_count, state); end
        tick();
        checks++; if (arr_step !== 1'b0 || gen_count !== 16'd1) begin errors++; $display("FAIL pause_step_once: got step=%b gen=%0d expected 0 1", arr_step, gen_count); end
        cmd_run = 1; tick(); cmd_run = 0;
        checks++; if (state !== 2'd2 || arr_step !== 1'b0) begin errors++; $display("FAIL resume: got state=%0d step=%b expected 2 0", state, arr_step); end
        tick();
        checks++; if (arr_step !== 1'b1 || gen_count !== 16'd2) begin errors++; $display("FAIL resume_held_timer: got step=%b gen=%0d expected 1 2", arr_step, gen_count); end
        cmd_load = 1; cmd_run = 1; tick(); idle_inputs();
        checks++; if (state !== 2'd1 || gen_count !== '0) begin errors++; $display("FAIL prio_load_run: got state=%0d gen=%0d expected 1 0", state, gen_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        gen_limit = '0;
        cmd_step = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (arr_step !== 1'b1 || gen_count !== GEN_W'(i) || state !== 2'd0) begin errors++; $display("FAIL b2b_step %0d: got step=%b gen=%0d state=%0d expected 1 %0d 0", i, arr_step, gen_count, state, i); end
        end
        cmd_step = 0; tick();
        checks++; if (arr_step !== 1'b0 || gen_count !== 16'd3) begin errors++; $display("FAIL b2b_end: got step=%b gen=%0d expected 0 3", arr_step, gen_count); end
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        do_reset();
        cfg_period = 8'd0; gen_limit = '0;
        cmd_run = 1; tick(); cmd_run = 0;
        repeat (7) tick();
        checks++; if (gen_count !== 16'd7 || state !== 2'd2) begin errors++; $display("FAIL midrun_pre: got gen=%0d state=%0d expected 7 2", gen_count, state); end
        rst = 1; tick(); rst = 0;
        checks++; if (state !== 2'd0 || gen_count !== '0 || arr_step !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrun_reset: got state=%0d gen=%0d step=%b expected 0 0 0", state, gen_count, arr_step); end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (arr_step === 1'b1) pulses++;
        end
        checks++; if (pulses != 0 || state !== 2'd0) begin errors++; $display("FAIL midrun_quiet: got pulses=%0d state=%0d expected 0 0", pulses, state); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_stall();
        test_run_timing();
        test_limit();
        test_pause_step();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
